// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, falling-edge start detect, 3-sample majority
// vote at mid-bit, optional even/odd parity, one stop bit, one-cycle result strobes.
module uart_rx #(
  parameter int width      = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX_in,
  input  logic             Par_en,
  input  logic             Par_type,
  output logic [width-1:0] P_data,
  output logic             Data_valid,
  output logic             Par_err,
  output logic             Stop_err,
  output logic             Busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] MID_LO    = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID       = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] MID_HI    = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST_EDGE = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q;
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]    edge_cnt_q;
  logic [IW-1:0]    bit_idx_q;
  logic [width-1:0] shift_q;
  logic             par_en_q, par_type_q, par_bad_q;
  logic             smp0_q, smp1_q;
  logic [width-1:0] p_data_q;
  logic             data_valid_q, par_err_q, stop_err_q, busy_q;

  logic start_det, sample_now, bit_d;

  assign start_det  = rx_prev_q & ~rx_s_q;
  assign sample_now = (edge_cnt_q == MID_HI);
  // Majority of the two latched mid-bit samples and the current one.
  assign bit_d = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      edge_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      par_bad_q    <= 1'b0;
      smp0_q       <= 1'b1;
      smp1_q       <= 1'b1;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q    <= RX_in;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;

      if (edge_cnt_q == MID_LO) smp0_q <= rx_s_q;
      if (edge_cnt_q == MID)    smp1_q <= rx_s_q;

      if (state_q != IDLE)
        edge_cnt_q <= (edge_cnt_q == LAST_EDGE) ? '0 : edge_cnt_q + CW'(1);

      // Every state leaves at its own mid-bit decision; the edge counter keeps
      // running, so the next state's samples land on the centre of the next bit.
      case (state_q)
        IDLE: begin
          edge_cnt_q <= '0;
          if (start_det) begin
            state_q    <= START;
            edge_cnt_q <= CW'(1);
            busy_q     <= 1'b1;
            par_en_q   <= Par_en;
            par_type_q <= Par_type;
            par_bad_q  <= 1'b0;
            bit_idx_q  <= '0;
          end
        end
        START: begin
          if (sample_now) begin
            if (bit_d) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (sample_now) begin
            shift_q   <= {bit_d, shift_q[width-1:1]};
            bit_idx_q <= bit_idx_q + IW'(1);
            if (bit_idx_q == LAST_BIT) state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (sample_now) begin
            par_bad_q <= (bit_d != ((^shift_q) ^ par_type_q));
            state_q   <= STOP;
          end
        end
        STOP: begin
          // Leave at the stop decision so a short stop bit cannot hide the next start.
          if (sample_now) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (bit_d && !par_bad_q) begin
              p_data_q     <= shift_q;
              data_valid_q <= 1'b1;
            end
            if (!bit_d)   stop_err_q <= 1'b1;
            if (par_bad_q) par_err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign P_data     = p_data_q;
  assign Data_valid = data_valid_q;
  assign Par_err    = par_err_q;
  assign Stop_err   = stop_err_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame table driven into RX_in, expected strobes queued at
// frame start and matched (flags, cycle, data) when the DUT strobes.
module tb_uart_rx;

  localparam int OS = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_in;
  logic       Par_en;
  logic       Par_type;
  logic [7:0] P_data;
  logic       Data_valid, Par_err, Stop_err, Busy;

  uart_rx #(.width(8), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX_in     (RX_in),
    .Par_en    (Par_en),
    .Par_type  (Par_type),
    .P_data    (P_data),
    .Data_valid(Data_valid),
    .Par_err   (Par_err),
    .Stop_err  (Stop_err),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       dv, pe, se;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par_en, par_type, par_flip, stop_bit;
    int         stop_len, gap, low_after;
    logic       glitch;
    logic       dv, pe, se;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[11];
  int   tests = 0;
  int   fails = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_level(input logic v, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      RX_in = (i == glitch_at) ? ~v : v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input vec_t v);
    int   k;
    int   nbits;
    logic par_bit;
    Par_en   = v.par_en;
    Par_type = v.par_type;
    k        = cyc;
    nbits    = 2 + 8 + (v.par_en ? 1 : 0);
    exp_q.push_back('{v.data, v.dv, v.pe, v.se, k + 2 + (nbits - 1) * OS + OS / 2 + 2});
    drive_level(1'b0, OS, -1);
    // Flip the controls mid-frame: the receiver must use the values latched at start.
    Par_en   = ~v.par_en;
    Par_type = ~v.par_type;
    for (int b = 0; b < 8; b++) drive_level(v.data[b], OS, v.glitch ? OS / 2 : -1);
    if (v.par_en) begin
      par_bit = (^v.data) ^ v.par_type ^ v.par_flip;
      drive_level(par_bit, OS, -1);
    end
    drive_level(v.stop_bit, v.stop_len, -1);
    if (v.low_after > 0) begin
      drive_level(1'b0, v.low_after, -1);
      check("busy_while_line_low", Busy, 1'b0);
    end
    drive_level(1'b1, v.gap, -1);
  endtask

  initial begin
    //           data   pen  ptp  flip stop len gap low glitch dv   pe   se
    vecs[0]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8, 4, 0,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 8, 4, 0,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h37, 1'b1, 1'b0, 1'b1, 1'b1, 8, 4, 0,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'h37, 1'b1, 1'b1, 1'b0, 1'b1, 8, 4, 0,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8, 4, 20, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 8, 4, 0,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8, 4, 0,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 7, 0, 0,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 7, 0, 0,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 7, 4, 0,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{8'h96, 1'b1, 1'b1, 1'b1, 1'b0, 8, 4, 0,  1'b0, 1'b0, 1'b1, 1'b1};

    rst      = 1'b1;
    RX_in    = 1'b1;
    Par_en   = 1'b0;
    Par_type = 1'b0;

    // Strobe monitor / scoreboard, forked so all bookkeeping lives in one process.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
          last_good = 8'h00;
        end else if (Data_valid || Par_err || Stop_err) begin
          $display("[TB] strobe cyc=%0d dv=%0b pe=%0b se=%0b P_data=%02h",
                   cyc, Data_valid, Par_err, Stop_err, P_data);
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", {Data_valid, Par_err, Stop_err}, 3'b000);
          end else begin
            e = exp_q.pop_front();
            check("strobe_flags", {Data_valid, Par_err, Stop_err}, {e.dv, e.pe, e.se});
            check("strobe_cycle", cyc, e.cyc);
            check("p_data", P_data, e.dv ? e.data : last_good);
            check("busy_at_strobe", Busy, 1'b0);
            if (e.dv) last_good = e.data;
          end
        end
      end
    join_none

    repeat (4) @(posedge clk);
    #1;
    check("reset_p_data", P_data, 8'h00);
    check("reset_data_valid", Data_valid, 1'b0);
    check("reset_par_err", Par_err, 1'b0);
    check("reset_stop_err", Stop_err, 1'b0);
    check("reset_busy", Busy, 1'b0);
    rst = 1'b0;
    drive_level(1'b1, 6, -1);

    for (int i = 0; i < 11; i++) send_frame(vecs[i]);

    // Two-cycle low pulse: start is seen, then rejected at the start-bit sample.
    begin
      int k;
      k = cyc;
      drive_level(1'b0, 2, -1);
      drive_level(1'b1, 2, -1);
      check("glitch_busy_high", Busy, 1'b1);
      drive_level(1'b1, 10, -1);
      check("glitch_back_idle", Busy, 1'b0);
      $display("[TB] glitch pulse at cyc=%0d done", k);
    end

    // Reset during data bit 4, then a clean frame.
    begin
      vec_t v;
      Par_en = 1'b0;
      drive_level(1'b0, OS, -1);
      for (int b = 0; b < 4; b++) drive_level(b[0], OS, -1);
      drive_level(1'b0, 3, -1);
      check("busy_before_reset", Busy, 1'b1);
      rst   = 1'b1;
      RX_in = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midreset_p_data", P_data, 8'h00);
      check("midreset_strobes", {Data_valid, Par_err, Stop_err}, 3'b000);
      check("midreset_busy", Busy, 1'b0);
      drive_level(1'b1, 30, -1);
      check("after_reset_idle", Busy, 1'b0);
      v = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8, 4, 0, 1'b0, 1'b1, 1'b0, 1'b0};
      send_frame(v);
    end

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the serial link: recovers frames of start bit, `width` data bits LSB-first, an optional parity bit and one stop bit from `RX_in`, and presents each good byte as a one-cycle `Data_valid` strobe on `P_data`. It is the receive-side counterpart of the UART transmit path and uses the same frame format and parity convention. `clk` is the oversampling clock: one bit period is `OVERSAMPLE` cycles.

## Interface
- `width`, 8: data bits per frame.
- `OVERSAMPLE`, 8: `clk` cycles per bit. Must be even and at least 4.

- `clk`  in  1  oversampling clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `RX_in`  in  1  serial line, asynchronous to `clk`, idle high.
- `Par_en`  in  1  when 1, the frame carries a parity bit.
- `Par_type`  in  1  0 selects even parity, 1 selects odd parity.
- `P_data`  out  `width`  last good received word.
- `Data_valid`  out  1  one-cycle strobe: `P_data` is new and good.
- `Par_err`  out  1  one-cycle strobe: parity mismatch in the completed frame.
- `Stop_err`  out  1  one-cycle strobe: stop bit sampled 0.
- `Busy`  out  1  high while a frame is being received.

## Operation
- **Synchronizer:** `RX_in` passes through a 2-flop synchronizer that resets to 1. Its output `rx_s` drives everything else.
- **Start detection:** an edge detector flags a start when `rx_s` was 1 on the previous cycle and is 0 now. A line held low never re-triggers a start.
- **Per-frame control latch:** `Par_en` and `Par_type` are latched at start detection and held for the whole frame.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a falling edge of `rx_s`.
  - START -> DATA if the start bit is sampled 0. If it is sampled 1 (glitch), go back to IDLE with no strobes.
  - DATA -> PARITY after `width` bits when the latched `Par_en` is 1, otherwise DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE right after the stop decision, without waiting for the end of the stop bit. This tolerates baud drift on back-to-back frames.
- **Bit counter (`edge_cnt`):** counts 0..OVERSAMPLE-1 within each bit and wraps into the next bit. A separate counter tracks the data-bit index, 0..width-1.
- **Bit sampling:** majority vote of the `rx_s` values at `edge_cnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is made in the cycle where `edge_cnt` = OVERSAMPLE/2+1.
- **Data:** bits are shifted in LSB first.
- **Parity:**
  - Expected parity = XOR of the data bits (even) or its inverse (odd).
  - A mismatch is recorded but the stop bit is still checked.
  - With parity disabled, `Par_err` never asserts.
- **Stop decision:**
  - Stop = 1 and no parity error: `P_data` <= shift register and `Data_valid` pulses.
  - Stop = 0: `Stop_err` pulses.
  - Parity error: `Par_err` pulses.
  - `Par_err` and `Stop_err` can pulse together.
  - `Data_valid` never pulses in the same cycle as an error strobe.
  - `P_data` holds its previous value on any error.
- **Busy:** high from the cycle after start detection through the cycle the FSM returns to IDLE.
- **Reset mid-frame:** FSM goes to IDLE, counters clear, no strobe is issued, and the partial frame is discarded.

## Timing
- **Reset values:**
  - `P_data` = 0, `Data_valid` = 0, `Par_err` = 0, `Stop_err` = 0, `Busy` = 0.
  - Synchronizer flops = 1, FSM in IDLE.
- **Synchronizer latency:** a change on `RX_in` appears on `rx_s` 2 cycles later.
- **Cycle reference:**
  - T is the cycle in which IDLE sees the falling edge of `rx_s`. T is `edge_cnt` = 0 of the start bit.
  - K = 2 + width + Par_en is the number of bits in the frame.
- **Strobe timing:** all strobes are registered and asserted in cycle T + (K-1)*OVERSAMPLE + OVERSAMPLE/2 + 2, for exactly one cycle.
  - width 8, OVERSAMPLE 8, no parity: T+78.
  - Same with parity: T+86.
- **Next frame:** the FSM is in IDLE from the strobe cycle onward. A falling edge seen in that cycle or later starts a new frame.

## Test plan
- **Good byte, no parity:** `Par_en`=0, send 0xA5 at 8 cycles/bit -> `Data_valid`=1 for one cycle at T+78, `P_data`=0xA5, `Busy` low at T+78.
- **Parity both ways:** `Par_en`=1. Send 0x37 with `Par_type`=0 and parity bit 1 -> `Data_valid` at T+86 with `P_data`=0x37. Resend 0x37 with parity bit 0 -> `Par_err` pulse at T+86, no `Data_valid`, `P_data` unchanged.
- **Stop error then recovery:** send 0x5A with stop bit 0, then hold the line low for 20 cycles -> `Stop_err` pulse, no new frame detected while low. Next a valid 0x81 frame -> `Data_valid` with `P_data`=0x81.
- **Glitch and noise rejection:** a 2-cycle low pulse on an idle line -> FSM back in IDLE, no strobes. A 1-cycle inverted glitch at the centre of each data bit of 0xC3 -> still received as 0xC3.
- **Back-to-back frames with drift:** frames 0x01, 0xFE, 0x55 sent with 7-cycle stop bits and no idle gap -> three `Data_valid` pulses with correct data.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 -> all outputs 0, no strobe. The next full frame 0x3C is received correctly.
